// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and baud helper.
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  function automatic int bit_ticks(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop (N >= 2) synchronizer for asynchronous inputs, resets to 1 (idle line level).
module uart_sync #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] r_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_q <= '1;
    else r_q <= {r_q[N-2:0], i_d};
  assign o_q = r_q[N-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, false-start, framing and overrun detection.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (perr reports mismatches).
module uart_rx
  import uart_pkg::*;
#(
  parameter int Clock = 50000000,
  parameter int Baud  = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       ovr,
  output logic       perr
);
  localparam int BitTicks = bit_ticks(Clock, Baud);
  localparam int HalfTicks = BitTicks / 2;
  localparam int CW = $clog2(BitTicks);
  localparam logic [CW-1:0] BIT_M1 = CW'(BitTicks - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HalfTicks - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_sr;
  logic w_rxs, w_tick, w_done, w_ferr, w_perr;
  uart_sync #(.N(2)) u_sync (.clock(clock), .reset(reset), .i_d(rxd), .o_q(w_rxs));
  assign w_tick = r_cnt == '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!w_rxs) w_next = START;
      START:   if (w_tick) w_next = w_rxs ? IDLE : DATA;
      DATA:    if (w_tick && r_idx == 3'(DATA_BITS - 1)) w_next = AFTER_DATA;
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_tick) w_next = w_rxs ? IDLE : BREAK;
      BREAK:   if (w_rxs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_done = r_state == STOP && w_tick && w_rxs;
    w_ferr = r_state == STOP && w_tick && !w_rxs;
  end
`ifdef UART_RX_PARITY_EN
  logic r_par;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_par <= 1'b0;
    else if (r_state == PARITY && w_tick) r_par <= w_rxs;
  assign w_perr = w_done && ^{r_sr, r_par};
`else
  assign w_perr = 1'b0;
`endif
  // IDLE keeps reloading the half-bit delay so a start edge lands mid-bit
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_sr  <= '0;
      data  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
      perr  <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE) ? HALF_M1 : w_tick ? BIT_M1 : r_cnt - 1'b1;
      r_idx <= (r_state == DATA) ? r_idx + 3'(w_tick) : '0;
      if (r_state == DATA && w_tick) r_sr <= {w_rxs, r_sr[7:1]};
      if (w_done) data <= r_sr;
      valid <= w_done | (valid & ~ack);
      ferr  <= w_ferr;
      ovr   <= w_done & valid & ~ack;
      perr  <= w_perr;
    end
endmodule
